// File: rtl/rv32i_multicycle_ctrl.sv
// rtl/rv32i_multicycle_ctrl.sv - RV32I multi-cycle control sequencer (optional MEM timeout: MCCTRL_TIMEOUT_EN)
module rv32i_multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_rdata,
    input  logic        mem_ready,
    input  logic        btaken,
    output logic        ir_en,
    output logic        pc_en,
    output logic [1:0]  pc_mux_sel,
    output logic        register_write_en,
    output logic [1:0]  rd_mux_en,
    output logic        imm_en,
    output logic        alu_a_pc,
    output logic [3:0]  alu_control_en,
    output logic        mem_write_en,
    output logic        mem_read_en,
    output logic [2:0]  mem_size,
    output logic        illegal_instr,
    output logic        bus_error,
    output logic [31:0] instret
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4
    } state_t;

    state_t      state;
    logic [31:0] ir;
    logic [31:0] instret_q;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_b5;
    logic        supported;
    logic        is_store;
    logic        is_mem_op;
    logic        timeout_hit;

    assign opcode    = ir[6:0];
    assign funct3    = ir[14:12];
    assign funct7_b5 = ir[30];
    assign is_store  = (opcode == OP_STORE);
    assign is_mem_op = (opcode == OP_LOAD) || is_store;

    // Register and immediate fields are decoded by the datapath, not here.
    logic unused_ir_bits;
    assign unused_ir_bits = ^{ir[31], ir[29:15], ir[11:7]};

    // Classify the latched opcode as supported or illegal.
    always_comb begin
        supported = 1'b0;
        case (opcode)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: supported = 1'b1;
            default:                           supported = 1'b0;
        endcase
    end

`ifdef MCCTRL_TIMEOUT_EN
    logic [31:0] wait_cnt;

    assign timeout_hit = (state == S_MEM) && !mem_ready &&
                         (wait_cnt == 32'(MEM_TIMEOUT - 1));

    // MEM wait counter: cleared on the way into MEM, counts not-ready cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state == S_EXECUTE) begin
            wait_cnt <= '0;
        end else if (state == S_MEM && !mem_ready) begin
            wait_cnt <= wait_cnt + 32'd1;
        end
    end
`else
    localparam int unsigned unused_mem_timeout = MEM_TIMEOUT;
    assign timeout_hit = 1'b0;
`endif

    logic        ir_en_c;
    logic        pc_en_c;
    logic [1:0]  pc_mux_sel_c;
    logic        register_write_en_c;
    logic [1:0]  rd_mux_en_c;
    logic        imm_en_c;
    logic        alu_a_pc_c;
    logic [3:0]  alu_control_en_c;
    logic        mem_write_en_c;
    logic        mem_read_en_c;
    logic        illegal_instr_c;
    logic        bus_error_c;

    // Per-state control decode; combinational so MEM completion and reset act in the same cycle.
    always_comb begin
        ir_en_c             = 1'b0;
        pc_en_c             = 1'b0;
        pc_mux_sel_c        = 2'b00;
        register_write_en_c = 1'b0;
        rd_mux_en_c         = 2'b00;
        imm_en_c            = 1'b0;
        alu_a_pc_c          = 1'b0;
        alu_control_en_c    = 4'b0000;
        mem_write_en_c      = 1'b0;
        mem_read_en_c       = 1'b0;
        illegal_instr_c     = 1'b0;
        bus_error_c         = 1'b0;
        case (state)
            S_FETCH: begin
                ir_en_c = 1'b1;
            end
            S_DECODE: begin
                if (!supported) begin
                    illegal_instr_c = 1'b1;
                    pc_en_c         = 1'b1;
                end
            end
            S_EXECUTE: begin
                pc_en_c = !is_mem_op;
                case (opcode)
                    OP_R: begin
                        alu_control_en_c    = {funct7_b5, funct3};
                        register_write_en_c = 1'b1;
                    end
                    OP_I: begin
                        imm_en_c            = 1'b1;
                        // Only the shift-right pair uses bit 30 as an op selector.
                        alu_control_en_c    = (funct3 == 3'b101) ? {funct7_b5, funct3}
                                                                 : {1'b0, funct3};
                        register_write_en_c = 1'b1;
                    end
                    OP_LUI: begin
                        register_write_en_c = 1'b1;
                        rd_mux_en_c         = 2'b11;
                    end
                    OP_AUIPC: begin
                        alu_a_pc_c          = 1'b1;
                        imm_en_c            = 1'b1;
                        register_write_en_c = 1'b1;
                    end
                    OP_JAL: begin
                        register_write_en_c = 1'b1;
                        rd_mux_en_c         = 2'b10;
                        pc_mux_sel_c        = 2'b01;
                    end
                    OP_JALR: begin
                        register_write_en_c = 1'b1;
                        rd_mux_en_c         = 2'b10;
                        imm_en_c            = 1'b1;
                        pc_mux_sel_c        = 2'b10;
                    end
                    OP_BRANCH: begin
                        pc_mux_sel_c = btaken ? 2'b01 : 2'b00;
                    end
                    default: begin
                        imm_en_c = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                imm_en_c       = 1'b1;
                mem_write_en_c = is_store;
                mem_read_en_c  = !is_store;
                if (mem_ready) begin
                    pc_en_c = is_store;
                end else if (timeout_hit) begin
                    bus_error_c = 1'b1;
                    pc_en_c     = 1'b1;
                end
            end
            S_WB: begin
                register_write_en_c = 1'b1;
                rd_mux_en_c         = 2'b01;
                pc_en_c             = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Sequencer state, instruction latch and retirement counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_FETCH;
            ir        <= NOP;
            instret_q <= '0;
        end else begin
            if (pc_en_c) begin
                instret_q <= instret_q + 32'd1;
            end
            case (state)
                S_FETCH: begin
                    ir    <= instr_rdata;
                    state <= S_DECODE;
                end
                S_DECODE:  state <= supported ? S_EXECUTE : S_FETCH;
                S_EXECUTE: state <= is_mem_op ? S_MEM : S_FETCH;
                S_MEM: begin
                    if (mem_ready) begin
                        state <= is_store ? S_FETCH : S_WB;
                    end else if (timeout_hit) begin
                        state <= S_FETCH;
                    end
                end
                S_WB:      state <= S_FETCH;
                default:   state <= S_FETCH;
            endcase
        end
    end

    assign ir_en             = reset ? 1'b0    : ir_en_c;
    assign pc_en             = reset ? 1'b0    : pc_en_c;
    assign pc_mux_sel        = reset ? 2'b00   : pc_mux_sel_c;
    assign register_write_en = reset ? 1'b0    : register_write_en_c;
    assign rd_mux_en         = reset ? 2'b00   : rd_mux_en_c;
    assign imm_en            = reset ? 1'b0    : imm_en_c;
    assign alu_a_pc          = reset ? 1'b0    : alu_a_pc_c;
    assign alu_control_en    = reset ? 4'b0000 : alu_control_en_c;
    assign mem_write_en      = reset ? 1'b0    : mem_write_en_c;
    assign mem_read_en       = reset ? 1'b0    : mem_read_en_c;
    assign mem_size          = reset ? 3'b000  : funct3;
    assign illegal_instr     = reset ? 1'b0    : illegal_instr_c;
    assign bus_error         = reset ? 1'b0    : bus_error_c;
    assign instret           = reset ? 32'd0   : instret_q;

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// tb/tb_rv32i_multicycle_ctrl.sv - scoreboard testbench for rv32i_multicycle_ctrl
module tb_rv32i_multicycle_ctrl;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_rdata;
    logic        mem_ready;
    logic        btaken;
    logic        ir_en;
    logic        pc_en;
    logic [1:0]  pc_mux_sel;
    logic        register_write_en;
    logic [1:0]  rd_mux_en;
    logic        imm_en;
    logic        alu_a_pc;
    logic [3:0]  alu_control_en;
    logic        mem_write_en;
    logic        mem_read_en;
    logic [2:0]  mem_size;
    logic        illegal_instr;
    logic        bus_error;
    logic [31:0] instret;

    rv32i_multicycle_ctrl #(.MEM_TIMEOUT(TMO)) dut (
        .clk               (clk),
        .reset             (reset),
        .instr_rdata       (instr_rdata),
        .mem_ready         (mem_ready),
        .btaken            (btaken),
        .ir_en             (ir_en),
        .pc_en             (pc_en),
        .pc_mux_sel        (pc_mux_sel),
        .register_write_en (register_write_en),
        .rd_mux_en         (rd_mux_en),
        .imm_en            (imm_en),
        .alu_a_pc          (alu_a_pc),
        .alu_control_en    (alu_control_en),
        .mem_write_en      (mem_write_en),
        .mem_read_en       (mem_read_en),
        .mem_size          (mem_size),
        .illegal_instr     (illegal_instr),
        .bus_error         (bus_error),
        .instret           (instret)
    );

    always #5 clk = ~clk;

    // {ir_en, pc_en, pc_mux_sel, rwe, rd_mux, imm_en, alu_a_pc, alu_ctl, mwe, mre, mem_size, illegal, bus_error}
    logic [19:0] act;
    assign act = {ir_en, pc_en, pc_mux_sel, register_write_en, rd_mux_en, imm_en, alu_a_pc,
                  alu_control_en, mem_write_en, mem_read_en, mem_size, illegal_instr, bus_error};

    logic [19:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_instret;
    logic [2:0]  ir_f3;

    function automatic logic [19:0] ev(input logic ire, input logic pce, input logic [1:0] pcs,
                                       input logic rwe, input logic [1:0] rdm, input logic imm,
                                       input logic apc, input logic [3:0] alu, input logic mwe,
                                       input logic mre, input logic [2:0] msz, input logic ill,
                                       input logic be);
        return {ire, pce, pcs, rwe, rdm, imm, apc, alu, mwe, mre, msz, ill, be};
    endfunction

    // Reference model: per-cycle expected outputs for one instruction.
    task automatic push_model(input logic [31:0] instr, input logic bt, input int waits,
                              input bit to);
        logic [6:0] op;
        logic [2:0] f3;
        logic       b30;
        bit         st;
        int         m;
        op  = instr[6:0];
        f3  = instr[14:12];
        b30 = instr[30];
        exp_q.push_back(ev(1, 0, 2'b00, 0, 2'b00, 0, 0, 4'h0, 0, 0, ir_f3, 0, 0));
        ir_f3 = f3;
        if (!(op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                         7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111})) begin
            exp_q.push_back(ev(0, 1, 2'b00, 0, 2'b00, 0, 0, 4'h0, 0, 0, f3, 1, 0));
            return;
        end
        exp_q.push_back(ev(0, 0, 2'b00, 0, 2'b00, 0, 0, 4'h0, 0, 0, f3, 0, 0));
        case (op)
            7'b0110011: exp_q.push_back(ev(0, 1, 2'b00, 1, 2'b00, 0, 0, {b30, f3}, 0, 0, f3, 0, 0));
            7'b0010011: exp_q.push_back(ev(0, 1, 2'b00, 1, 2'b00, 1, 0,
                                           (f3 == 3'b101) ? {b30, f3} : {1'b0, f3}, 0, 0, f3, 0, 0));
            7'b0110111: exp_q.push_back(ev(0, 1, 2'b00, 1, 2'b11, 0, 0, 4'h0, 0, 0, f3, 0, 0));
            7'b0010111: exp_q.push_back(ev(0, 1, 2'b00, 1, 2'b00, 1, 1, 4'h0, 0, 0, f3, 0, 0));
            7'b1101111: exp_q.push_back(ev(0, 1, 2'b01, 1, 2'b10, 0, 0, 4'h0, 0, 0, f3, 0, 0));
            7'b1100111: exp_q.push_back(ev(0, 1, 2'b10, 1, 2'b10, 1, 0, 4'h0, 0, 0, f3, 0, 0));
            7'b1100011: exp_q.push_back(ev(0, 1, bt ? 2'b01 : 2'b00, 0, 2'b00, 0, 0, 4'h0, 0, 0, f3, 0, 0));
            default: begin
                st = (op == 7'b0100011);
                exp_q.push_back(ev(0, 0, 2'b00, 0, 2'b00, 1, 0, 4'h0, 0, 0, f3, 0, 0));
                m = to ? TMO : waits + 1;
                for (int i = 0; i < m; i++) begin
                    exp_q.push_back(ev(0, (i == m - 1) && (st || to), 2'b00, 0, 2'b00, 1, 0, 4'h0,
                                       st, !st, f3, 0, (i == m - 1) && to));
                end
                if (!st && !to) begin
                    exp_q.push_back(ev(0, 1, 2'b00, 1, 2'b01, 0, 0, 4'h0, 0, 0, f3, 0, 0));
                end
            end
        endcase
    endtask

    // Drive one instruction from its FETCH cycle; compare every cycle against the scoreboard.
    task automatic run_instr(input string name, input logic [31:0] instr, input logic bt,
                             input int waits, input bit to);
        int          n;
        logic [19:0] e;
        push_model(instr, bt, waits, to);
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            instr_rdata = (k == 0) ? instr : 32'hFFFF_FFFF;
            btaken      = bt;
            mem_ready   = (k < 3) ? 1'b1 : (!to && k == 3 + waits);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s cycle %0d outputs got %h expected %h", name, k, act, e);
            end
            @(posedge clk);
            #1;
        end
        exp_instret++;
        checks++;
        if (instret !== exp_instret) begin
            errors++;
            $display("FAIL %s instret got %0d expected %0d", name, instret, exp_instret);
        end
    endtask

    task automatic test_reset;
        reset       = 1'b1;
        instr_rdata = 32'h0000_0000;
        mem_ready   = 1'b1;
        btaken      = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (act !== 20'h0 || instret !== 32'd0) begin
            errors++;
            $display("FAIL reset outputs got %h/%0d expected 0/0", act, instret);
        end
        @(posedge clk);
        #1;
        reset       = 1'b0;
        exp_instret = 32'd0;
        ir_f3       = 3'b000;
    endtask

    task automatic test_alu;
        run_instr("add",       32'h0020_81B3, 1'b0, 0, 1'b0);
        run_instr("sub",       32'h4020_8233, 1'b0, 0, 1'b0);
        run_instr("addi_b30",  32'h4000_0093, 1'b0, 0, 1'b0);
        run_instr("srai",      32'h4030_D093, 1'b0, 0, 1'b0);
        run_instr("slti",      32'h0050_A113, 1'b0, 0, 1'b0);
    endtask

    task automatic test_utype_jump;
        run_instr("lui",   32'h0000_12B7, 1'b0, 0, 1'b0);
        run_instr("auipc", 32'h0000_1297, 1'b0, 0, 1'b0);
        run_instr("jal",   32'h0080_00EF, 1'b0, 0, 1'b0);
        run_instr("jalr",  32'h0000_80E7, 1'b0, 0, 1'b0);
    endtask

    task automatic test_branch;
        run_instr("beq_taken",    32'h0020_8463, 1'b1, 0, 1'b0);
        run_instr("beq_nottaken", 32'h0020_8463, 1'b0, 0, 1'b0);
    endtask

    task automatic test_load_store;
        run_instr("lw_wait3", 32'h0041_2283, 1'b0, 3, 1'b0);
        run_instr("lw_wait0", 32'h0041_2283, 1'b0, 0, 1'b0);
        run_instr("lbu",      32'h0041_4283, 1'b0, 1, 1'b0);
        run_instr("sw_wait0", 32'h0051_2423, 1'b0, 0, 1'b0);
        run_instr("sb_wait2", 32'h0051_0423, 1'b0, 2, 1'b0);
    endtask

    task automatic test_illegal;
        run_instr("fence", 32'h0000_000F, 1'b0, 0, 1'b0);
        run_instr("zero",  32'h0000_0000, 1'b0, 0, 1'b0);
        run_instr("after_illegal_add", 32'h0020_81B3, 1'b0, 0, 1'b0);
    endtask

`ifdef MCCTRL_TIMEOUT_EN
    task automatic test_timeout;
        run_instr("sw_timeout",     32'h0051_2423, 1'b0, 0, 1'b1);
        run_instr("lw_timeout",     32'h0041_2283, 1'b0, 0, 1'b1);
        run_instr("sw_ready_at_to", 32'h0051_2423, 1'b0, TMO - 1, 1'b0);
        run_instr("lw_ready_at_to", 32'h0041_2283, 1'b0, TMO - 1, 1'b0);
    endtask
`else
    task automatic test_long_wait;
        run_instr("sw_long_wait", 32'h0051_2423, 1'b0, 20, 1'b0);
        run_instr("lw_long_wait", 32'h0041_2283, 1'b0, 20, 1'b0);
    endtask
`endif

    task automatic test_back_to_back;
        logic [31:0] prog [8];
        prog[0] = 32'h0020_81B3;
        prog[1] = 32'h0041_2283;
        prog[2] = 32'h0020_8463;
        prog[3] = 32'h0051_2423;
        prog[4] = 32'h0000_000F;
        prog[5] = 32'h4030_D093;
        prog[6] = 32'h0000_80E7;
        prog[7] = 32'h0000_12B7;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 8; i++) begin
                run_instr("b2b", prog[i], 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'b0);
            end
        end
    endtask

    task automatic test_reset_mid_mem;
        instr_rdata = 32'h0051_2423;
        btaken      = 1'b0;
        mem_ready   = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            instr_rdata = 32'hFFFF_FFFF;
        end
        @(negedge clk);
        checks++;
        if (mem_write_en !== 1'b1) begin
            errors++;
            $display("FAIL mid_mem_setup mem_write_en got %b expected 1", mem_write_en);
        end
        #4;
        reset = 1'b1;
        #1;
        checks++;
        if (act !== 20'h0 || instret !== 32'd0) begin
            errors++;
            $display("FAIL mid_mem_reset outputs got %h/%0d expected 0/0", act, instret);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (act !== ev(1, 0, 2'b00, 0, 2'b00, 0, 0, 4'h0, 0, 0, 3'b000, 0, 0) || instret !== 32'd0) begin
            errors++;
            $display("FAIL after_mid_mem_reset outputs got %h/%0d expected %h/0", act, instret,
                     ev(1, 0, 2'b00, 0, 2'b00, 0, 0, 4'h0, 0, 0, 3'b000, 0, 0));
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset       = 1'b0;
        exp_instret = 32'd0;
        ir_f3       = 3'b000;
        run_instr("add_after_reset", 32'h0020_81B3, 1'b0, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_alu();
        test_utype_jump();
        test_branch();
        test_load_store();
        test_illegal();
`ifdef MCCTRL_TIMEOUT_EN
        test_timeout();
`else
        test_long_wait();
`endif
        test_back_to_back();
        test_reset_mid_mem();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
